// File: rtl/data_memory_bytelane_if.sv
// Request/response bundle between the LSU and data_memory_bytelane.
//
// Signals:
//   req_valid   master -> slave  request present
//   req_ready   slave  -> master request can be accepted this cycle
//   req_write   master -> slave  1 = store, 0 = load
//   req_funct3  master -> slave  RV32I load/store funct3
//   req_addr    master -> slave  byte address (ADDR_W bits)
//   req_wdata   master -> slave  store data, LSB-aligned
//   rsp_valid   slave  -> master one-cycle response pulse
//   rsp_rdata   slave  -> master extended load data (0 for stores/errors)
//   rsp_err     slave  -> master request rejected
interface data_memory_bytelane_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_memory_bytelane.sv
// Single-port RV32I data memory with byte-lane stores, sign/zero-extended
// loads, a one-cycle registered response and a hardware zero-fill after reset.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    data_memory_bytelane_if.slave request/response bundle
//   busy   high while the post-reset zero-fill is running
//
// Optional macro DMEM_MISALIGN_CHECK_EN: when defined, misaligned half/word
// accesses are rejected with rsp_err; otherwise the offset is forced down to
// the natural alignment of the access.
module data_memory_bytelane #(
  parameter  int DEPTH  = 32,
  parameter  int ADDR_W = 32,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  data_memory_bytelane_if.slave  bus,
  output logic                   busy
);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] clear_idx;
  logic [31:0]      mem [DEPTH];

  logic [ADDR_W-1:0] addr;
  logic [IDX_W-1:0]  word_idx;
  logic [1:0]        offset;
  logic [1:0]        half_off;
  logic              accept;
  logic              funct_ok;
  logic              misaligned;
  logic              req_err;
  logic [3:0]        byte_en;
  logic [31:0]       wr_lanes;
  logic [31:0]       rd_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       load_data;
  logic              unused_addr_bits;

  assign addr     = bus.req_addr;
  assign word_idx = addr[IDX_W+1:2];
  assign offset   = addr[1:0];
  // Half accesses always use lane 0 or 2; bit 0 is either rejected or dropped.
  assign half_off = {offset[1], 1'b0};
  // Upper address bits are deliberately ignored so the address space wraps.
  assign unused_addr_bits = &{1'b0, addr[ADDR_W-1:IDX_W+2]};

  // State register; clear_idx wraps back to 0 as the fill finishes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= CLEAR;
      clear_idx <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR) clear_idx <= clear_idx + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      CLEAR: if (clear_idx == IDX_W'(DEPTH - 1)) state_next = IDLE;
      IDLE:  state_next = IDLE;
      default: state_next = CLEAR;
    endcase
  end

  always_comb begin
    busy          = (state == CLEAR);
    bus.req_ready = (state == IDLE);
  end

  assign accept = bus.req_valid & bus.req_ready;

  // Lane enables and replicated store data; unsigned load funct3 codes are
  // only legal for loads.
  always_comb begin
    funct_ok = 1'b0;
    byte_en  = 4'b0000;
    wr_lanes = '0;
    case (bus.req_funct3)
      3'b000: begin
        funct_ok = 1'b1;
        byte_en  = 4'b0001 << offset;
        wr_lanes = {4{bus.req_wdata[7:0]}};
      end
      3'b001: begin
        funct_ok = 1'b1;
        byte_en  = 4'b0011 << half_off;
        wr_lanes = {2{bus.req_wdata[15:0]}};
      end
      3'b010: begin
        funct_ok = 1'b1;
        byte_en  = 4'b1111;
        wr_lanes = bus.req_wdata;
      end
      3'b100, 3'b101: funct_ok = ~bus.req_write;
      default: funct_ok = 1'b0;
    endcase
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misaligned = ((bus.req_funct3[1:0] == 2'b01) && offset[0]) ||
                      ((bus.req_funct3[1:0] == 2'b10) && (offset != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign req_err = ~funct_ok | misaligned;

  // Asynchronous array read at the acceptance edge, so a load right after a
  // store to the same word sees the freshly written data.
  assign rd_word = mem[word_idx];
  assign rd_byte = rd_word[{offset, 3'b000} +: 8];
  assign rd_half = rd_word[{half_off, 3'b000} +: 16];

  always_comb begin
    load_data = '0;
    case (bus.req_funct3)
      3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  load_data = {24'b0, rd_byte};
      3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
      3'b101:  load_data = {16'b0, rd_half};
      3'b010:  load_data = rd_word;
      default: load_data = '0;
    endcase
  end

  // Zero-fill has priority; no requests are accepted while it runs anyway.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == CLEAR) begin
        mem[clear_idx] <= '0;
      end else if (accept && bus.req_write && !req_err) begin
        for (int i = 0; i < 4; i++) begin
          if (byte_en[i]) mem[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
        end
      end
    end
  end

  // Response registers hold data/err across idle cycles; only valid pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.rsp_valid <= accept;
      if (accept) begin
        bus.rsp_err   <= req_err;
        bus.rsp_rdata <= (bus.req_write || req_err) ? 32'h0 : load_data;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_bytelane.sv
// Directed testbench for data_memory_bytelane (DEPTH = 32). Expected values
// are hand-computed; expectations for misaligned accesses follow
// DMEM_MISALIGN_CHECK_EN.
module tb_data_memory_bytelane;

  localparam int DEPTH = 32;

  localparam logic [2:0] F_B   = 3'b000;
  localparam logic [2:0] F_H   = 3'b001;
  localparam logic [2:0] F_W   = 3'b010;
  localparam logic [2:0] F_BU  = 3'b100;
  localparam logic [2:0] F_HU  = 3'b101;
  localparam logic [2:0] F_BAD = 3'b011;
  localparam logic [2:0] F_BD2 = 3'b111;

  logic clk;
  logic rst_n;
  logic busy;

  int checks;
  int errors;

  data_memory_bytelane_if #(.ADDR_W(32)) bus ();

  data_memory_bytelane #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop so a wedged run still ends with a failure report.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Called at a negedge; issues one request, waits for the acceptance edge,
  // then checks the response at the following negedge. Consecutive calls
  // therefore produce back-to-back requests.
  task automatic applyStimulus(input string tag, input logic write,
                               input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata,
                               input logic [31:0] exp_rdata, input logic exp_err);
    bus.req_valid  = 1'b1;
    bus.req_write  = write;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    checkOutput({tag, ".valid"}, 32'(bus.rsp_valid), 32'd1);
    checkOutput({tag, ".rdata"}, bus.rsp_rdata, exp_rdata);
    checkOutput({tag, ".err"},   32'(bus.rsp_err), 32'(exp_err));
  endtask

  // Called at the negedge where rst_n is released; measures the busy window.
  task automatic waitClear(input string tag);
    int  cnt;
    logic ready_seen;
    cnt = 0;
    ready_seen = 1'b0;
    while (busy && cnt < 100) begin
      if (bus.req_ready) ready_seen = 1'b1;
      cnt++;
      @(negedge clk);
    end
    checkOutput({tag, ".busy_cycles"}, 32'(cnt), 32'(DEPTH));
    checkOutput({tag, ".ready_in_clear"}, 32'(ready_seen), 32'd0);
    checkOutput({tag, ".ready_after"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = F_W;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;

    repeat (2) @(negedge clk);
    checkOutput("rst.busy",  32'(busy),          32'd1);
    checkOutput("rst.ready", 32'(bus.req_ready), 32'd0);
    checkOutput("rst.valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("rst.rdata", bus.rsp_rdata,      32'd0);
    checkOutput("rst.err",   32'(bus.rsp_err),   32'd0);

    rst_n = 1'b1;
    waitClear("clr0");
    applyStimulus("lw7c", 1'b0, F_W, 32'h7C, 32'h0, 32'h0, 1'b0);

    // Sign/zero extension of bytes and halves.
    applyStimulus("sw10",   1'b1, F_W,  32'h10, 32'h80F0_7F01, 32'h0, 1'b0);
    applyStimulus("lb10",   1'b0, F_B,  32'h10, 32'h0, 32'h0000_0001, 1'b0);
    applyStimulus("lb11",   1'b0, F_B,  32'h11, 32'h0, 32'h0000_007F, 1'b0);
    applyStimulus("lb12",   1'b0, F_B,  32'h12, 32'h0, 32'hFFFF_FFF0, 1'b0);
    applyStimulus("lbu12",  1'b0, F_BU, 32'h12, 32'h0, 32'h0000_00F0, 1'b0);
    applyStimulus("lh12",   1'b0, F_H,  32'h12, 32'h0, 32'hFFFF_80F0, 1'b0);
    applyStimulus("lhu10",  1'b0, F_HU, 32'h10, 32'h0, 32'h0000_7F01, 1'b0);
    applyStimulus("lhu12",  1'b0, F_HU, 32'h12, 32'h0, 32'h0000_80F0, 1'b0);
    applyStimulus("lb13",   1'b0, F_B,  32'h13, 32'h0, 32'hFFFF_FF80, 1'b0);

    // Byte-lane merging, back-to-back, with read-after-write on the same word.
    applyStimulus("sw20",   1'b1, F_W,  32'h20, 32'hAABB_CCDD, 32'h0, 1'b0);
    applyStimulus("sb21",   1'b1, F_B,  32'h21, 32'hFFFF_FF11, 32'h0, 1'b0);
    applyStimulus("sh22",   1'b1, F_H,  32'h22, 32'hFFFF_2233, 32'h0, 1'b0);
    applyStimulus("lw20",   1'b0, F_W,  32'h20, 32'h0, 32'h2233_11DD, 1'b0);

    // Address wrap modulo 4*DEPTH.
    applyStimulus("sw84",   1'b1, F_W,  32'h84, 32'h1234_5678, 32'h0, 1'b0);
    applyStimulus("lw04",   1'b0, F_W,  32'h04, 32'h0, 32'h1234_5678, 1'b0);
    applyStimulus("lw484",  1'b0, F_W,  32'h484, 32'h0, 32'h1234_5678, 1'b0);

    // Illegal funct3: no write, error response, held across an idle cycle.
    applyStimulus("sw08",   1'b1, F_W,   32'h08, 32'hCAFE_F00D, 32'h0, 1'b0);
    applyStimulus("bad08",  1'b1, F_BAD, 32'h08, 32'h5555_5555, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("idle.valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("idle.err",   32'(bus.rsp_err),   32'd1);
    applyStimulus("lw08",   1'b0, F_W,   32'h08, 32'h0, 32'hCAFE_F00D, 1'b0);
    applyStimulus("sbu08",  1'b1, F_BU,  32'h08, 32'h0000_0000, 32'h0, 1'b1);
    applyStimulus("bad2",   1'b0, F_BD2, 32'h08, 32'h0, 32'h0, 1'b1);
    applyStimulus("lw08b",  1'b0, F_W,   32'h08, 32'h0, 32'hCAFE_F00D, 1'b0);

    // Misaligned half/word accesses.
    applyStimulus("sw00",   1'b1, F_W,  32'h00, 32'h9ABC_1234, 32'h0, 1'b0);
`ifdef DMEM_MISALIGN_CHECK_EN
    applyStimulus("lh03",   1'b0, F_H,  32'h03, 32'h0, 32'h0, 1'b1);
    applyStimulus("lw02",   1'b0, F_W,  32'h02, 32'h0, 32'h0, 1'b1);
    applyStimulus("sh01",   1'b1, F_H,  32'h01, 32'h0000_5566, 32'h0, 1'b1);
    applyStimulus("lw00",   1'b0, F_W,  32'h00, 32'h0, 32'h9ABC_1234, 1'b0);
`else
    applyStimulus("lh03",   1'b0, F_H,  32'h03, 32'h0, 32'hFFFF_9ABC, 1'b0);
    applyStimulus("lw02",   1'b0, F_W,  32'h02, 32'h0, 32'h9ABC_1234, 1'b0);
    applyStimulus("sh01",   1'b1, F_H,  32'h01, 32'h0000_5566, 32'h0, 1'b0);
    applyStimulus("lw00",   1'b0, F_W,  32'h00, 32'h0, 32'h9ABC_5566, 1'b0);
`endif

    // Reset right after a load is accepted: response dropped, memory refilled.
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_funct3 = F_W;
    bus.req_addr   = 32'h20;
    @(posedge clk);
    #1;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("mid.valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("mid.busy",  32'(busy),          32'd1);
    checkOutput("mid.ready", 32'(bus.req_ready), 32'd0);
    rst_n = 1'b1;
    waitClear("clr1");
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus($sformatf("zero%0d", i), 1'b0, F_W, 32'(i * 4), 32'h0,
                    32'h0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_bytelane.md
Name: data_memory_bytelane

Overview:
- Parametrised successor to the single-cycle word data memory.
- Single-port RISC-V data memory with a valid/ready request interface.
- Handles the RV32I load/store size variants: byte/half/word accesses with byte-lane writes and sign/zero-extended loads.
- Registered read with one-cycle response latency; hardware zero-fill sequence after reset. Sits between the LSU/execute stage and the register writeback path.

Parameters:
- DEPTH, 32, number of 32-bit words; power of two, minimum 4.
- ADDR_W, 32, width of the byte address input.
- IDX_W, $clog2(DEPTH), word-index width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 of the load/store.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, LSB-aligned (rs2).
- rsp_valid  out  1  response pulse, one cycle.
- rsp_rdata  out  32  extended load result; 0 for stores and errors.
- rsp_err  out  1  request rejected (illegal funct3 or misaligned).
- busy  out  1  zero-fill in progress.

Behaviour:
- States: CLEAR, IDLE.
- Reset: rst_n low at a clk edge → state CLEAR, clear index = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, busy = 1, req_ready = 0.
  - Reset mid-operation drops any pending response; the clear sequence restarts from index 0.
- CLEAR:
  - Writes 0 to word[clear index] each cycle and increments the index.
  - After word DEPTH-1 is written → IDLE; busy = 0, req_ready = 1 from the next cycle.
  - Total CLEAR duration is DEPTH cycles after rst_n is released.
  - Requests during CLEAR are not accepted (req_ready = 0); the requester must hold them.
- IDLE:
  - req_ready = 1 constantly; one request accepted per cycle when req_valid & req_ready. Back-to-back requests are supported.
- Addressing:
  - Word index = req_addr[IDX_W+1:2]; upper address bits are ignored, so the address wraps modulo 4*DEPTH.
  - Byte offset = req_addr[1:0].
- Accepted load:
  - rsp_valid = 1 on the next cycle.
  - funct3 000 LB / 100 LBU: selected byte, sign-/zero-extended.
  - funct3 001 LH / 101 LHU: half at offset 0 or 2, sign-/zero-extended.
  - funct3 010 LW: full word.
- Accepted store:
  - Written at the acceptance edge.
  - funct3 000 SB: byte lane = offset, data = wdata[7:0].
  - funct3 001 SH: lanes offset, offset+1, data = wdata[15:0].
  - funct3 010 SW: all four lanes.
  - Unselected lanes are unchanged.
  - rsp_valid pulses next cycle with rsp_rdata = 0 (write ack).
- Errors:
  - Any other funct3 value (load or store) → no memory write; next-cycle rsp_valid = 1, rsp_err = 1, rsp_rdata = 0.
- Ordering:
  - A load accepted the cycle after a store to the same word returns the updated data (no stale read).
- Idle cycle: when no request is accepted, rsp_valid = 0 next cycle; rsp_rdata and rsp_err hold their previous values.

Optional Feature:
- Macro: DMEM_MISALIGN_CHECK_EN.
- Defined: a half access with offset[0] = 1 or a word access with offset != 0 → no write; response has rsp_err = 1, rsp_rdata = 0.
- Undefined: misaligned offsets are forced down to alignment (half uses offset & 2, word uses offset 0); rsp_err is only raised for illegal funct3.

Test Plan:
- Reset release → busy = 1 for exactly 32 cycles (DEPTH = 32), req_ready = 0 throughout; then LW addr 0x7C → rsp_rdata = 0x00000000 one cycle after acceptance.
- SW 0x80F0_7F01 @0x10, then LB/LBU/LH/LHU @0x10, 0x11, 0x12 → LB 0x10 = 0x00000001; LB 0x12 = 0xFFFFFFF0; LBU 0x12 = 0x000000F0; LH 0x12 = 0xFFFF80F0; LHU 0x10 = 0x00007F01.
- SW 0xAABBCCDD @0x20, then SB 0x11 @0x21, then SH 0x2233 @0x22 back-to-back, then LW @0x20 → 0x223311DD; each request gets a one-cycle rsp_valid.
- Wrap-around: SW 0x12345678 @0x84 → LW @0x04 returns 0x12345678.
- funct3 = 011 store @0x08 → rsp_err = 1, word 0x08 unchanged. LH @0x03 → rsp_err = 1 with DMEM_MISALIGN_CHECK_EN defined; returns the half at offset 2 without it.
- Reset asserted one cycle after a LW is accepted → no rsp_valid; busy = 1; all words read 0 after the clear completes.
